// File: rtl/pipe_store_rng_if.sv
// Purpose : bundles the pipe-list and RNG signals of pipe_store_rng.
// Ports   : master = game CPU side (drives enables, insert and iterator
//           requests); slave = pipe_store_rng (drives count, current
//           element and rng_out).
interface pipe_store_rng_if #(
    parameter int unsigned X_WIDTH   = 12,
    parameter int unsigned Y_WIDTH   = 11,
    parameter int unsigned OUT_WIDTH = 9
);
    localparam int unsigned CNT_WIDTH = 5;

    logic                 list_ce;
    logic                 rng_ce;
    logic [CNT_WIDTH-1:0] count;
    logic                 insert_en;
    logic [X_WIDTH-1:0]   insert_x;
    logic [Y_WIDTH-1:0]   insert_y;
    logic                 iter_start;
    logic [X_WIDTH-1:0]   iter_in_x;
    logic [Y_WIDTH-1:0]   iter_in_y;
    logic                 iter_remove;
    logic [X_WIDTH-1:0]   iter_out_x;
    logic [Y_WIDTH-1:0]   iter_out_y;
    logic                 iter_out_valid;
    logic [OUT_WIDTH-1:0] rng_out;

    modport master (
        output list_ce, rng_ce, insert_en, insert_x, insert_y,
               iter_start, iter_in_x, iter_in_y, iter_remove,
        input  count, iter_out_x, iter_out_y, iter_out_valid, rng_out
    );

    modport slave (
        input  list_ce, rng_ce, insert_en, insert_x, insert_y,
               iter_start, iter_in_x, iter_in_y, iter_remove,
        output count, iter_out_x, iter_out_y, iter_out_valid, rng_out
    );
endinterface

// File: rtl/pipe_store_rng.sv
// Purpose : game-state helper holding a bounded, insertion-ordered list of
//           pipe records with a streaming modify/remove iterator, plus a
//           bounded Galois-LFSR generator for new pipe gap heights.
// Ports   : clk  - single rising-edge clock
//           rst  - synchronous active-low reset
//           bus  - pipe_store_rng_if.slave: list_ce/rng_ce enables, insert
//                  request, iterator start/write-back/remove, count,
//                  current element, rng_out
module pipe_store_rng #(
    parameter int unsigned CAPACITY  = 16,
    parameter int unsigned X_WIDTH   = 12,
    parameter int unsigned Y_WIDTH   = 11,
    parameter int unsigned OUT_WIDTH = 9,
    parameter int unsigned OUT_MIN   = 1,
    parameter int unsigned OUT_MAX   = 279
) (
    input  logic               clk,
    input  logic               rst,
    pipe_store_rng_if.slave    bus
);
    localparam int unsigned CNT_WIDTH  = 5;
    localparam int unsigned IDX_WIDTH  = (CAPACITY > 1) ? $clog2(CAPACITY) : 1;
    localparam int unsigned LFSR_WIDTH = 16;
    localparam logic [LFSR_WIDTH-1:0] LFSR_SEED = 16'hACE1;
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 16'hB400;

    typedef struct packed {
        logic [X_WIDTH-1:0] x;
        logic [Y_WIDTH-1:0] y;
    } pipe_rec_t;

    // ------------------------------------------------------------------
    // List state
    // ------------------------------------------------------------------
    pipe_rec_t            r_mem [CAPACITY];
    logic [CNT_WIDTH-1:0] r_count;
    logic [CNT_WIDTH-1:0] r_rd;
    logic [CNT_WIDTH-1:0] r_wr;
    logic                 r_valid;
    pipe_rec_t            r_cur;

    logic [CNT_WIDTH-1:0] w_count_nxt;
    logic [CNT_WIDTH-1:0] w_rd_nxt;
    logic [CNT_WIDTH-1:0] w_wr_nxt;
    logic                 w_valid_nxt;
    pipe_rec_t            w_cur_nxt;
    logic                 w_mem_we;
    logic [CNT_WIDTH-1:0] w_mem_waddr;
    pipe_rec_t            w_mem_wdata;

    logic [CNT_WIDTH-1:0] w_rd_inc;
    logic                 w_more;
    pipe_rec_t            w_wb_rec;
    pipe_rec_t            w_ins_rec;

    assign w_rd_inc  = r_rd + CNT_WIDTH'(1);
    assign w_more    = (w_rd_inc < r_count);
    assign w_wb_rec  = '{x: bus.iter_in_x, y: bus.iter_in_y};
    assign w_ins_rec = '{x: bus.insert_x,  y: bus.insert_y};

    // Next-state for list control: restart > advance > insert.
    always_comb begin
        w_count_nxt = r_count;
        w_rd_nxt    = r_rd;
        w_wr_nxt    = r_wr;
        w_valid_nxt = r_valid;
        w_cur_nxt   = r_cur;
        w_mem_we    = 1'b0;
        w_mem_waddr = r_wr;
        w_mem_wdata = w_wb_rec;

        if (bus.list_ce) begin
            if (bus.iter_start) begin
                w_rd_nxt    = '0;
                w_wr_nxt    = '0;
                w_valid_nxt = (r_count != '0);
                // An empty list leaves the last presented element in place.
                if (r_count != '0) begin
                    w_cur_nxt = r_mem[0];
                end
            end else if (r_valid) begin
                // Survivors are written back at wr, which never passes rd,
                // so the read of rd+1 below always sees pre-edge contents.
                if (!bus.iter_remove) begin
                    w_mem_we    = 1'b1;
                    w_mem_waddr = r_wr;
                    w_mem_wdata = w_wb_rec;
                    w_wr_nxt    = r_wr + CNT_WIDTH'(1);
                end
                w_rd_nxt = w_rd_inc;
                if (w_more) begin
                    w_cur_nxt = r_mem[IDX_WIDTH'(w_rd_inc)];
                end else begin
                    // Final step: the compacted survivor count becomes the length.
                    w_valid_nxt = 1'b0;
                    w_count_nxt = r_wr + CNT_WIDTH'(!bus.iter_remove);
                end
            end else if (bus.insert_en && (r_count < CNT_WIDTH'(CAPACITY))) begin
                w_mem_we    = 1'b1;
                w_mem_waddr = r_count;
                w_mem_wdata = w_ins_rec;
                w_count_nxt = r_count + CNT_WIDTH'(1);
            end
        end
    end

    // List control registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
            r_rd    <= '0;
            r_wr    <= '0;
            r_valid <= 1'b0;
            r_cur   <= '0;
        end else begin
            r_count <= w_count_nxt;
            r_rd    <= w_rd_nxt;
            r_wr    <= w_wr_nxt;
            r_valid <= w_valid_nxt;
            r_cur   <= w_cur_nxt;
        end
    end

    // Record storage; contents beyond count are don't-care, so no reset.
    always_ff @(posedge clk) begin
        if (rst && w_mem_we) begin
            r_mem[IDX_WIDTH'(w_mem_waddr)] <= w_mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Bounded RNG
    // ------------------------------------------------------------------
    logic [LFSR_WIDTH-1:0] r_lfsr;
    logic [OUT_WIDTH-1:0]  r_rng;
    logic [LFSR_WIDTH-1:0] w_lfsr_nxt;
    logic [OUT_WIDTH-1:0]  w_cand;
    logic                  w_cand_ok;

    assign w_lfsr_nxt = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : '0);
    assign w_cand     = w_lfsr_nxt[OUT_WIDTH-1:0];
    assign w_cand_ok  = (w_cand >= OUT_WIDTH'(OUT_MIN)) && (w_cand <= OUT_WIDTH'(OUT_MAX));

    // Out-of-range candidates are dropped so rng_out never leaves the range.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_lfsr <= LFSR_SEED;
            r_rng  <= OUT_WIDTH'(OUT_MIN);
        end else if (bus.rng_ce) begin
            r_lfsr <= w_lfsr_nxt;
            if (w_cand_ok) begin
                r_rng <= w_cand;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.count          = r_count;
    assign bus.iter_out_x     = r_cur.x;
    assign bus.iter_out_y     = r_cur.y;
    assign bus.iter_out_valid = r_valid;
    assign bus.rng_out        = r_rng;

endmodule

// File: tb/tb_pipe_store_rng.sv
// Purpose : self-checking bench for pipe_store_rng; directed scenarios
//           followed by randomized traffic, all checked against a
//           queue-based list model and an arithmetic LFSR model.
module tb_pipe_store_rng;
    localparam int unsigned CAP  = 16;
    localparam int unsigned XW   = 12;
    localparam int unsigned YW   = 11;
    localparam int unsigned OW   = 9;
    localparam int unsigned OMIN = 1;
    localparam int unsigned OMAX = 279;

    typedef struct {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
    } rec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_store_rng_if #(.X_WIDTH(XW), .Y_WIDTH(YW), .OUT_WIDTH(OW)) bus ();

    pipe_store_rng #(
        .CAPACITY(CAP), .X_WIDTH(XW), .Y_WIDTH(YW),
        .OUT_WIDTH(OW), .OUT_MIN(OMIN), .OUT_MAX(OMAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    rec_t        m_q[$];
    rec_t        m_new[$];
    int          m_idx;
    bit          m_valid;
    rec_t        m_cur;
    int unsigned m_lfsr;
    int unsigned m_rng;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        int unsigned nxt;
        int unsigned cand;
        rec_t r;
        if (!rst) begin
            m_q.delete();
            m_new.delete();
            m_valid = 1'b0;
            m_idx   = 0;
            m_cur.x = '0;
            m_cur.y = '0;
            m_lfsr  = 32'hACE1;
            m_rng   = OMIN;
        end else begin
            if (bus.list_ce) begin
                if (bus.iter_start) begin
                    if (m_q.size() != 0) begin
                        m_valid = 1'b1;
                        m_idx   = 0;
                        m_cur   = m_q[0];
                        m_new.delete();
                    end
                end else if (m_valid) begin
                    if (!bus.iter_remove) begin
                        r.x = bus.iter_in_x;
                        r.y = bus.iter_in_y;
                        m_new.push_back(r);
                    end
                    m_idx++;
                    if (m_idx < m_q.size()) begin
                        m_cur = m_q[m_idx];
                    end else begin
                        m_valid = 1'b0;
                        m_q = m_new;
                    end
                end else if (bus.insert_en && m_q.size() < CAP) begin
                    r.x = bus.insert_x;
                    r.y = bus.insert_y;
                    m_q.push_back(r);
                end
            end
            if (bus.rng_ce) begin
                nxt = (m_lfsr / 2) ^ ((m_lfsr % 2 == 1) ? 32'hB400 : 32'h0);
                m_lfsr = nxt;
                cand = nxt % (1 << OW);
                if (cand >= OMIN && cand <= OMAX) m_rng = cand;
            end
        end
    endtask

    task automatic check_all();
        check_eq("count", 32'(bus.count), 32'(m_q.size()));
        check_eq("valid", 32'(bus.iter_out_valid), 32'(m_valid));
        if (m_valid) begin
            check_eq("iter_x", 32'(bus.iter_out_x), 32'(m_cur.x));
            check_eq("iter_y", 32'(bus.iter_out_y), 32'(m_cur.y));
        end
        check_eq("rng", 32'(bus.rng_out), m_rng);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Write back the current element, optionally with x decremented.
    task automatic write_back(input bit dec_x);
        bus.iter_in_x = dec_x ? (m_cur.x - XW'(1)) : m_cur.x;
        bus.iter_in_y = m_cur.y;
    endtask

    task automatic insert(input int x, input int y);
        bus.insert_en = 1'b1;
        bus.insert_x  = XW'(x);
        bus.insert_y  = YW'(y);
        tick();
        bus.insert_en = 1'b0;
    endtask

    initial begin
        int exp_y3[3];
        int exp_y2[2];
        exp_y3 = '{10, 20, 30};
        exp_y2 = '{20, 30};

        rst = 1'b0;
        bus.list_ce     = 1'b1;
        bus.rng_ce      = 1'b0;
        bus.insert_en   = 1'b0;
        bus.insert_x    = '0;
        bus.insert_y    = '0;
        bus.iter_start  = 1'b0;
        bus.iter_in_x   = '0;
        bus.iter_in_y   = '0;
        bus.iter_remove = 1'b0;
        tick();
        tick();
        check_eq("rst_out_x", 32'(bus.iter_out_x), 32'd0);
        check_eq("rst_out_y", 32'(bus.iter_out_y), 32'd0);
        check_eq("rst_rng", 32'(bus.rng_out), 32'd1);
        rst = 1'b1;

        // RNG sequence from the seed: 112, hold on 312, then 156.
        bus.rng_ce = 1'b1;
        tick(); check_eq("rng_e1", 32'(bus.rng_out), 32'd112);
        tick(); check_eq("rng_e2", 32'(bus.rng_out), 32'd112);
        tick(); check_eq("rng_e3", 32'(bus.rng_out), 32'd156);
        bus.rng_ce = 1'b0;

        insert(639, 10);
        insert(639, 20);
        insert(639, 30);
        check_eq("count3", 32'(bus.count), 32'd3);

        // Iterate with x-1 write-back; an insert attempt mid-iteration is ignored.
        bus.iter_start = 1'b1; tick(); bus.iter_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_eq("it1_y", 32'(bus.iter_out_y), 32'(exp_y3[k]));
            write_back(1'b1);
            bus.insert_en = (k == 0);
            bus.insert_x  = XW'(5);
            bus.insert_y  = YW'(5);
            tick();
        end
        bus.insert_en = 1'b0;
        check_eq("it1_end_valid", 32'(bus.iter_out_valid), 32'd0);
        check_eq("it1_count", 32'(bus.count), 32'd3);

        bus.iter_start = 1'b1; tick(); bus.iter_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_eq("it2_x", 32'(bus.iter_out_x), 32'd638);
            write_back(1'b0);
            tick();
        end
        check_eq("it2_count", 32'(bus.count), 32'd3);

        // Remove the oldest element.
        bus.iter_start = 1'b1; tick(); bus.iter_start = 1'b0;
        bus.iter_remove = 1'b1; tick(); bus.iter_remove = 1'b0;
        for (int k = 0; k < 2; k++) begin
            write_back(1'b0);
            tick();
        end
        check_eq("rm_count", 32'(bus.count), 32'd2);
        bus.iter_start = 1'b1; tick(); bus.iter_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check_eq("rm_y", 32'(bus.iter_out_y), 32'(exp_y2[k]));
            write_back(1'b0);
            tick();
        end

        // Freeze mid-iteration with a pending remove.
        bus.iter_start = 1'b1; tick(); bus.iter_start = 1'b0;
        bus.list_ce = 1'b0;
        bus.iter_remove = 1'b1;
        repeat (5) tick();
        check_eq("frz_y", 32'(bus.iter_out_y), 32'd20);
        check_eq("frz_count", 32'(bus.count), 32'd2);
        bus.list_ce = 1'b1;
        tick();
        bus.iter_remove = 1'b0;
        check_eq("frz_next_y", 32'(bus.iter_out_y), 32'd30);
        write_back(1'b0);
        tick();
        check_eq("frz_count_after", 32'(bus.count), 32'd1);

        // Fill to capacity; the extra insert is dropped.
        for (int k = 0; k < 16; k++) insert(k, 100 + k);
        check_eq("full_count", 32'(bus.count), 32'd16);

        // Drain everything, then restart on the empty list.
        bus.iter_start = 1'b1; tick(); bus.iter_start = 1'b0;
        bus.iter_remove = 1'b1;
        repeat (16) tick();
        bus.iter_remove = 1'b0;
        check_eq("drain_count", 32'(bus.count), 32'd0);
        bus.iter_start = 1'b1; tick(); bus.iter_start = 1'b0;
        check_eq("empty_valid", 32'(bus.iter_out_valid), 32'd0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            rst             = ($urandom_range(0, 299) != 0);
            bus.list_ce     = ($urandom_range(0, 3) != 0);
            bus.rng_ce      = $urandom_range(0, 1);
            bus.insert_en   = ($urandom_range(0, 2) != 0);
            bus.insert_x    = XW'($urandom);
            bus.insert_y    = YW'($urandom);
            bus.iter_start  = (!m_valid && $urandom_range(0, 9) == 0);
            bus.iter_remove = ($urandom_range(0, 2) == 0);
            bus.iter_in_x   = XW'($urandom);
            bus.iter_in_y   = YW'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
